column_scroller: RTL and testbench

Playfield scroll stage that sits directly downstream of `coloum_pattern`. On each accepted scroll tick it shifts the stored playfield one column left and inserts a new column at the right edge. Every `PIPE_SPACING`-th new column is a pipe column fetched from the pattern generator; the rest are empty columns. After each shift it checks the bird position for a collision and updates the score. The display scanner reads the stored columns through a combinational read port.

---
 rtl/column_scroller.sv | 171 +++++++++++++++++
 tb/tb_column_scroller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_scroller.sv
// column_scroller
// Playfield scroll stage fed by the column pattern generator. Each accepted
// scroll tick shifts the stored playfield one column left and inserts a new
// column at the right edge: every PIPE_SPACING-th new column is a pipe fetched
// from the generator, the others are empty. After the shift the bird position
// is checked for a collision and the score is updated.
//
// Ports
//   clk          sole clock
//   reset        synchronous, active-low (0 = reset)
//   run          game active; ticks are ignored while low
//   scroll_tick  single-cycle scroll request
//   pattern_req  generator enable, one-cycle pulse per pipe column
//   pattern_in   generator column (bit i = row i, 1 = wall)
//   bird_row     current bird row, sampled in CHECK only
//   col_sel      read-port column select
//   col_data     column at col_sel (combinational), 0 when out of range
//   busy         high whenever the sequencer is not idle
//   collision    sticky game-over flag
//   score        pipes passed, saturating at 255
module column_scroller #(
    parameter int COLS         = 16,
    parameter int PIPE_SPACING = 4,
    parameter int BIRD_COL     = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic                      scroll_tick,
    output logic                      pattern_req,
    input  logic [15:0]               pattern_in,
    input  logic [3:0]                bird_row,
    input  logic [$clog2(COLS)-1:0]   col_sel,
    output logic [15:0]               col_data,
    output logic                      busy,
    output logic                      collision,
    output logic [7:0]                score
);

    localparam int CNT_W = (PIPE_SPACING > 2) ? $clog2(PIPE_SPACING) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        CHECK = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   spacing_cnt_q, spacing_cnt_d;
    logic [15:0]        new_col_q, new_col_d;
    logic               new_pipe_q, new_pipe_d;
    logic               collision_q, collision_d;
    logic [7:0]         score_q, score_d;
    logic [15:0]        col_q [COLS];
    logic [COLS-1:0]    pipe_q;
    logic               hit_s;
    logic               tick_ok_s;

    assign hit_s     = col_q[BIRD_COL][bird_row];
    // A tick is only taken while idle, running and not yet game-over.
    assign tick_ok_s = scroll_tick & run & ~collision_q;

    // Next-state and datapath-enable logic for the scroll sequencer.
    always_comb begin
        state_d       = state_q;
        spacing_cnt_d = spacing_cnt_q;
        new_col_d     = new_col_q;
        new_pipe_d    = new_pipe_q;
        collision_d   = collision_q;
        score_d       = score_q;
        case (state_q)
            IDLE: begin
                if (tick_ok_s) begin
                    if (spacing_cnt_q == CNT_W'(PIPE_SPACING - 1)) begin
                        spacing_cnt_d = '0;
                    end else begin
                        spacing_cnt_d = spacing_cnt_q + CNT_W'(1);
                    end
                    if (spacing_cnt_q == '0) begin
                        state_d = REQ;
                    end else begin
                        new_col_d  = 16'h0000;
                        new_pipe_d = 1'b0;
                        state_d    = SHIFT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                state_d = LOAD;
            end
            LOAD: begin
                // Generator advanced at the end of REQ; its output is valid now.
                new_col_d  = pattern_in;
                new_pipe_d = 1'b1;
                state_d    = SHIFT;
            end
            SHIFT: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (hit_s) begin
                    collision_d = 1'b1;
                end else if (pipe_q[BIRD_COL-1] && (score_q != 8'hFF)) begin
                    // The pipe just left the bird's column: it was passed.
                    score_d = score_q + 8'd1;
                end else begin
                    score_d = score_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and scalar registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            spacing_cnt_q <= '0;
            new_col_q     <= 16'h0000;
            new_pipe_q    <= 1'b0;
            collision_q   <= 1'b0;
            score_q       <= 8'd0;
        end else begin
            state_q       <= state_d;
            spacing_cnt_q <= spacing_cnt_d;
            new_col_q     <= new_col_d;
            new_pipe_q    <= new_pipe_d;
            collision_q   <= collision_d;
            score_q       <= score_d;
        end
    end

    // Playfield storage: shift left by one column on SHIFT, column 0 discarded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < COLS; i++) begin
                col_q[i] <= 16'h0000;
            end
            pipe_q <= '0;
        end else if (state_q == SHIFT) begin
            for (int i = 0; i < COLS - 1; i++) begin
                col_q[i] <= col_q[i+1];
            end
            col_q[COLS-1] <= new_col_q;
            pipe_q        <= {new_pipe_q, pipe_q[COLS-1:1]};
        end
    end

    // Combinational read port for the display scanner.
    always_comb begin
        col_data = 16'h0000;
        if (int'(col_sel) < COLS) begin
            col_data = col_q[col_sel];
        end else begin
            col_data = 16'h0000;
        end
    end

    assign pattern_req = (state_q == REQ);
    assign busy        = (state_q != IDLE);
    assign collision   = collision_q;
    assign score       = score_q;

endmodule

// File: tb/tb_column_scroller.sv
module tb_column_scroller;

    localparam int COLS = 16;
    localparam int SP   = 4;
    localparam int BIRD = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        scroll_tick;
    logic        pattern_req;
    logic [15:0] pattern_in;
    logic [3:0]  bird_row;
    logic [3:0]  col_sel;
    logic [15:0] col_data;
    logic        busy;
    logic        collision;
    logic [7:0]  score;

    int total = 0;
    int bad   = 0;

    column_scroller #(.COLS(COLS), .PIPE_SPACING(SP), .BIRD_COL(BIRD)) dut (
        .clk(clk), .reset(reset), .run(run), .scroll_tick(scroll_tick),
        .pattern_req(pattern_req), .pattern_in(pattern_in), .bird_row(bird_row),
        .col_sel(col_sel), .col_data(col_data), .busy(busy),
        .collision(collision), .score(score)
    );

    always #5 clk = ~clk;

    // Behavioural model: playfield as a queue, left edge at the front.
    typedef struct {
        logic [15:0] col;
        bit          pipe;
    } cell_t;

    cell_t m_field[$];
    int    m_ticks;
    int    m_score;
    bit    m_coll;

    // Observations of the last tick
    int          obs_req_n, obs_req_at, obs_busy_n;
    logic [15:0] obs_r[1:8];
    bit          exp_acc, exp_pipe;
    logic [15:0] exp_new, exp_old;

    task automatic model_clear();
        m_field.delete();
        for (int i = 0; i < COLS; i++) m_field.push_back('{16'h0000, 1'b0});
        m_ticks = 0;
        m_score = 0;
        m_coll  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        scroll_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    // One scroll tick plus 8 observed cycles; optional extra tick at cycle 'extra'.
    task automatic do_tick(input logic [15:0] pat, input int extra);
        cell_t c;
        exp_acc  = run && !m_coll;
        exp_pipe = exp_acc && ((m_ticks % SP) == 0);
        exp_old  = m_field[COLS-1].col;
        obs_req_n = 0; obs_req_at = 0; obs_busy_n = 0;
        @(negedge clk);
        col_sel     = 4'(COLS - 1);
        pattern_in  = ~pat;
        scroll_tick = 1'b1;
        for (int cy = 1; cy <= 8; cy++) begin
            @(negedge clk);
            scroll_tick = (cy == extra);
            obs_r[cy] = col_data;
            if (busy) obs_busy_n++;
            if (pattern_req) begin
                obs_req_n++;
                obs_req_at = cy;
                pattern_in = pat;
            end
        end
        scroll_tick = 1'b0;
        exp_new = 16'h0000;
        if (exp_acc) begin
            m_ticks++;
            exp_new = exp_pipe ? pat : 16'h0000;
            void'(m_field.pop_front());
            c.col = exp_new;
            c.pipe = exp_pipe;
            m_field.push_back(c);
            if (m_field[BIRD].col[bird_row]) m_coll = 1'b1;
            else if (m_field[BIRD-1].pipe && m_score < 255) m_score++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b1; scroll_tick = 1'b1;
        pattern_in = 16'($urandom); bird_row = 4'($urandom); col_sel = 4'd0;
        repeat (2) @(negedge clk);
        scroll_tick = 1'b0;
        reset = 1'b1;
        model_clear();
        #1;
        total++; if (score !== 8'd0) begin bad++; $display("FAIL reset_score got=%0d want=0", score); end
        total++; if (collision !== 1'b0) begin bad++; $display("FAIL reset_collision got=%b want=0", collision); end
        total++; if (pattern_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", pattern_req); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        for (int i = 0; i < COLS; i++) begin
            col_sel = 4'(i); #1;
            total++; if (col_data !== 16'h0000) begin bad++; $display("FAIL reset_col%0d got=%h want=0000", i, col_data); end
        end
    endtask

    task automatic test_handshake();
        run = 1'b1; bird_row = 4'd2;
        do_tick(16'hFFF1, 0);
        total++; if (obs_req_n !== 1) begin bad++; $display("FAIL hs_req_count got=%0d want=1", obs_req_n); end
        total++; if (obs_req_at !== 1) begin bad++; $display("FAIL hs_req_cycle got=%0d want=1", obs_req_at); end
        total++; if (obs_busy_n !== 4) begin bad++; $display("FAIL hs_busy got=%0d want=4", obs_busy_n); end
        total++; if (obs_r[3] !== 16'h0000) begin bad++; $display("FAIL hs_col15_c3 got=%h want=0000", obs_r[3]); end
        total++; if (obs_r[4] !== 16'hFFF1) begin bad++; $display("FAIL hs_col15_c4 got=%h want=fff1", obs_r[4]); end
    endtask

    task automatic test_spacing();
        logic [15:0] pat5, p;
        logic [15:0] want[4];
        pat5 = 16'h0;
        // Continues from the handshake tick, which was tick 1.
        for (int k = 2; k <= 8; k++) begin
            p = 16'($urandom);
            if (k == 5) pat5 = p;
            do_tick(p, 0);
            total++; if (obs_req_n !== ((k == 5) ? 1 : 0)) begin bad++; $display("FAIL spacing_req tick%0d got=%0d want=%0d", k, obs_req_n, (k == 5) ? 1 : 0); end
            total++; if (obs_busy_n !== ((k == 5) ? 4 : 2)) begin bad++; $display("FAIL spacing_busy tick%0d got=%0d", k, obs_busy_n); end
        end
        want[0] = 16'h0000; want[1] = 16'h0000; want[2] = 16'h0000; want[3] = pat5;
        for (int j = 0; j < 4; j++) begin
            col_sel = 4'(15 - j); #1;
            total++; if (col_data !== want[j]) begin bad++; $display("FAIL spacing_col%0d got=%h want=%h", 15 - j, col_data, want[j]); end
        end
    endtask

    task automatic test_pass_score();
        apply_reset();
        run = 1'b1; bird_row = 4'd2;
        for (int k = 1; k <= 14; k++) begin
            do_tick((k == 1) ? 16'hFFF1 : 16'($urandom), 0);
            if (k == 13) begin
                #1;
                total++; if (collision !== 1'b0) begin bad++; $display("FAIL pass_coll13 got=%b want=0", collision); end
                total++; if (score !== 8'd0) begin bad++; $display("FAIL pass_score13 got=%0d want=0", score); end
            end
        end
        #1;
        total++; if (score !== 8'd1) begin bad++; $display("FAIL pass_score14 got=%0d want=1", score); end
        total++; if (collision !== 1'b0) begin bad++; $display("FAIL pass_coll14 got=%b want=0", collision); end
    endtask

    task automatic test_collision();
        logic [15:0] snap[COLS];
        apply_reset();
        run = 1'b1; bird_row = 4'd0;
        for (int k = 1; k <= 13; k++) do_tick((k == 1) ? 16'hFFF1 : 16'($urandom), 0);
        #1;
        total++; if (collision !== 1'b1) begin bad++; $display("FAIL coll_flag got=%b want=1", collision); end
        total++; if (score !== 8'd0) begin bad++; $display("FAIL coll_score got=%0d want=0", score); end
        for (int i = 0; i < COLS; i++) snap[i] = m_field[i].col;
        for (int k = 0; k < 3; k++) begin
            bird_row = 4'($urandom);
            do_tick(16'($urandom), 0);
            total++; if (obs_busy_n !== 0 || obs_req_n !== 0) begin bad++; $display("FAIL coll_frozen busy=%0d req=%0d want=0/0", obs_busy_n, obs_req_n); end
        end
        for (int i = 0; i < COLS; i++) begin
            col_sel = 4'(i); #1;
            total++; if (col_data !== snap[i]) begin bad++; $display("FAIL coll_col%0d got=%h want=%h", i, col_data, snap[i]); end
        end
        total++; if (score !== 8'd0 || collision !== 1'b1) begin bad++; $display("FAIL coll_hold score=%0d coll=%b want=0/1", score, collision); end
    endtask

    task automatic test_drops();
        apply_reset();
        run = 1'b1; bird_row = 4'd5;
        do_tick(16'hA5A5, 2);
        total++; if (obs_busy_n !== 4 || obs_req_n !== 1) begin bad++; $display("FAIL drop_seq busy=%0d req=%0d want=4/1", obs_busy_n, obs_req_n); end
        col_sel = 4'd14; #1;
        total++; if (col_data !== 16'h0000) begin bad++; $display("FAIL drop_col14 got=%h want=0000", col_data); end
        col_sel = 4'd15; #1;
        total++; if (col_data !== 16'hA5A5) begin bad++; $display("FAIL drop_col15 got=%h want=a5a5", col_data); end
        run = 1'b0;
        do_tick(16'h1234, 0);
        total++; if (obs_busy_n !== 0 || obs_req_n !== 0) begin bad++; $display("FAIL gate_run busy=%0d req=%0d want=0/0", obs_busy_n, obs_req_n); end
        col_sel = 4'd15; #1;
        total++; if (col_data !== 16'hA5A5) begin bad++; $display("FAIL gate_col15 got=%h want=a5a5", col_data); end
        run = 1'b1;
        do_tick(16'h1234, 0);
        total++; if (obs_busy_n !== 2 || obs_req_n !== 0) begin bad++; $display("FAIL gate_resume busy=%0d req=%0d want=2/0", obs_busy_n, obs_req_n); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        run = 1'b1;
        do_tick(16'h00FF, 0);
        @(negedge clk);
        scroll_tick = 1'b1;
        @(negedge clk);
        scroll_tick = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        #1;
        total++; if (busy !== 1'b0 || pattern_req !== 1'b0) begin bad++; $display("FAIL midrst_idle busy=%b req=%b want=0/0", busy, pattern_req); end
        for (int i = 0; i < COLS; i++) begin
            col_sel = 4'(i); #1;
            total++; if (col_data !== 16'h0000) begin bad++; $display("FAIL midrst_col%0d got=%h want=0000", i, col_data); end
        end
        do_tick(16'h0F0F, 0);
        total++; if (obs_req_n !== 1) begin bad++; $display("FAIL midrst_pipe got=%0d want=1", obs_req_n); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 60; k++) begin
            run = ($urandom_range(0, 3) != 0);
            bird_row = 4'($urandom);
            do_tick(16'($urandom), $urandom_range(0, 1) * 2);
            total++; if (obs_req_n !== (exp_pipe ? 1 : 0)) begin bad++; $display("FAIL rnd_req k=%0d got=%0d want=%0d", k, obs_req_n, exp_pipe); end
            total++; if (obs_busy_n !== (exp_pipe ? 4 : (exp_acc ? 2 : 0))) begin bad++; $display("FAIL rnd_busy k=%0d got=%0d", k, obs_busy_n); end
            if (exp_acc) begin
                total++; if (obs_r[exp_pipe ? 4 : 2] !== exp_new) begin bad++; $display("FAIL rnd_new k=%0d got=%h want=%h", k, obs_r[exp_pipe ? 4 : 2], exp_new); end
                total++; if (obs_r[exp_pipe ? 3 : 1] !== exp_old) begin bad++; $display("FAIL rnd_old k=%0d got=%h want=%h", k, obs_r[exp_pipe ? 3 : 1], exp_old); end
            end
            #1;
            total++; if (collision !== m_coll || score !== 8'(m_score)) begin bad++; $display("FAIL rnd_status k=%0d coll=%b score=%0d want=%b/%0d", k, collision, score, m_coll, m_score); end
            for (int i = 0; i < COLS; i++) begin
                col_sel = 4'(i); #1;
                total++; if (col_data !== m_field[i].col) begin bad++; $display("FAIL rnd_col%0d k=%0d got=%h want=%h", i, k, col_data, m_field[i].col); end
            end
            if (m_coll && $urandom_range(0, 1) == 1) apply_reset();
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        run = 1'b1; bird_row = 4'($urandom);
        // All-gap pipes: every pipe is passed, one scored per 4 ticks from tick 14.
        for (int k = 1; k <= 1040; k++) begin
            do_tick(16'h0000, 0);
            if (k == 1026) begin
                #1;
                total++; if (score !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d want=254", score); end
            end
        end
        #1;
        total++; if (score !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d want=255", score); end
        total++; if (score !== 8'(m_score) || collision !== 1'b0) begin bad++; $display("FAIL sat_model got=%0d/%b want=%0d/0", score, collision, m_score); end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_spacing();
        test_pass_score();
        test_collision();
        test_drops();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
